// File: rtl/nand8_sweep_tester.sv
// nand8_sweep_tester: walks all 256 input patterns through one 8-input NAND
// gate, holds each for a programmable settle time, samples Y against the
// ideal ~&pattern and keeps pass/fail, error count and first failing pattern.
module nand8_sweep_tester #(
  parameter int SETTLE_CYCLES = 2,   // 1..255 clocks held before sampling
  parameter int STOP_ON_FAIL  = 0    // 1: finish at first mismatch
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       gate_y,
  output logic [7:0] gate_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_count,
  output logic [7:0] first_fail,
  output logic       fail_seen
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic       STOP_EN     = (STOP_ON_FAIL != 0);

  state_t     state, state_nxt;
  logic [7:0] settle_cnt;
  logic       mismatch;
  logic       settle_end;
  logic       stop_now;

  // Only a SAMPLE cycle judges the gate; outside it Y is ignored.
  assign mismatch   = (state == SAMPLE) && (gate_y != ~&gate_in);
  assign settle_end = (settle_cnt == SETTLE_LAST);
  // Run ends after the last pattern, or early on a failure when enabled.
  assign stop_now   = (&gate_in) || (STOP_EN && mismatch);
  assign busy       = (state == SETTLE) || (state == SAMPLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: abort outranks every busy transition; start outranks abort
  // when idle or done because abort is meaningless there.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start)         state_nxt = SETTLE;
      SETTLE: begin
        if (abort)                   state_nxt = IDLE;
        else if (settle_end)         state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (abort)                   state_nxt = IDLE;
        else if (stop_now)           state_nxt = DONE;
        else                         state_nxt = SETTLE;
      end
      default:                       state_nxt = IDLE;
    endcase
  end

  // Pattern, settle timer and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_in    <= '0;
      settle_cnt <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
      fail_seen  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            gate_in    <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
          end
        end
        SETTLE: begin
          if (abort) begin
            // Partial error info is kept for post-mortem after an abort.
            gate_in    <= '0;
            settle_cnt <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            gate_in    <= '0;
            settle_cnt <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
          end else begin
            if (mismatch) begin
              err_count <= err_count + 9'd1;
              if (!fail_seen) begin
                first_fail <= gate_in;
                fail_seen  <= 1'b1;
              end
            end
            if (stop_now) begin
              // gate_in stays on the last driven pattern while in DONE.
              done <= 1'b1;
              pass <= (err_count == 9'd0) && !mismatch;
            end else begin
              gate_in    <= gate_in + 8'd1;
              settle_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
